// File: rtl/pe_pkg.sv
// Shared constants for the weight-stationary PE (default widths and mode encodings).
// Optional saturation is selected elsewhere by defining PE_SAT_EN.
package pe_pkg;

   localparam int PE_A_WIDTH = 9;
   localparam int PE_W_WIDTH = 9;
   localparam int PE_P_WIDTH = 32;

   localparam logic PE_MODE_COMP = 1'b0;
   localparam logic PE_MODE_LOAD = 1'b1;

endpackage

// File: rtl/pe_sat_add.sv
// Signed P_WIDTH adder for the MAC stage-2 sum.
// Define PE_SAT_EN to clamp to the signed range instead of wrapping.
module pe_sat_add
   import pe_pkg::*;
#(
   parameter int P_WIDTH = PE_P_WIDTH
) (
   input  logic signed [P_WIDTH-1:0] a,
   input  logic signed [P_WIDTH-1:0] b,
   output logic signed [P_WIDTH-1:0] sum
);

`ifdef PE_SAT_EN
   localparam logic signed [P_WIDTH-1:0] SUM_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
   localparam logic signed [P_WIDTH-1:0] SUM_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

   logic signed [P_WIDTH:0] wide;

   // Overflow shows up as the two top bits of the widened sum disagreeing.
   always_comb begin
      wide = {a[P_WIDTH-1], a} + {b[P_WIDTH-1], b};
      if (wide[P_WIDTH] != wide[P_WIDTH-1])
         sum = wide[P_WIDTH] ? SUM_MIN : SUM_MAX;
      else
         sum = wide[P_WIDTH-1:0];
   end
`else
   assign sum = a + b;
`endif

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with double-buffered weight and a two-stage MAC pipeline.
// Define PE_SAT_EN to make the partial-sum add saturate instead of wrap.
module pe_ws_dbuf
   import pe_pkg::*;
#(
   parameter int A_WIDTH = PE_A_WIDTH,
   parameter int W_WIDTH = PE_W_WIDTH,
   parameter int P_WIDTH = PE_P_WIDTH
) (
   input  logic                      PE_clk,
   input  logic                      PE_rst,
   input  logic                      PE_mode,
   input  logic                      PE_swap,
   input  logic                      PE_en_up,
   input  logic        [P_WIDTH-1:0] PE_data_up,
   input  logic                      PE_en_left,
   input  logic        [A_WIDTH-1:0] PE_data_left,
   output logic                      PE_en_down,
   output logic        [P_WIDTH-1:0] PE_data_down,
   output logic                      PE_en_right,
   output logic        [A_WIDTH-1:0] PE_data_right,
   output logic                      PE_w_pend,
   output logic                      PE_err
);

   localparam int M_WIDTH = A_WIDTH + W_WIDTH;

   logic        [W_WIDTH-1:0] w_active;
   logic        [W_WIDTH-1:0] w_shadow;
   logic                      s1_valid;
   logic signed [M_WIDTH-1:0] s1_prod;
   logic signed [P_WIDTH-1:0] s1_psum;

   logic                      load_fwd;
   logic                      capture;
   logic                      do_swap;
   logic signed [M_WIDTH-1:0] act_ext;
   logic signed [M_WIDTH-1:0] wgt_ext;
   logic signed [M_WIDTH-1:0] prod_next;
   logic signed [P_WIDTH-1:0] prod_sext;
   logic signed [P_WIDTH-1:0] mac_sum;

   // Operands are sign-extended to the full product width so the multiply is exact.
   always_comb begin
      load_fwd  = (PE_mode == PE_MODE_LOAD) && PE_en_up;
      capture   = (PE_mode == PE_MODE_COMP) && (PE_en_left || PE_en_up);
      do_swap   = PE_swap && PE_w_pend;
      act_ext   = $signed({{W_WIDTH{PE_data_left[A_WIDTH-1]}}, PE_data_left});
      wgt_ext   = $signed({{A_WIDTH{w_active[W_WIDTH-1]}}, w_active});
      prod_next = PE_en_left ? act_ext * wgt_ext : '0;
      prod_sext = $signed({{(P_WIDTH-M_WIDTH){s1_prod[M_WIDTH-1]}}, s1_prod});
   end

   pe_sat_add #(
      .P_WIDTH (P_WIDTH)
   ) u_add (
      .a   (prod_sext),
      .b   (s1_psum),
      .sum (mac_sum)
   );

   // Stage 1 samples the active weight before any same-cycle swap lands, and a
   // load forward always owns the down port, flagging any stage-2 result it displaces.
   always_ff @(posedge PE_clk) begin
      if (PE_rst) begin
         w_active      <= '0;
         w_shadow      <= '0;
         s1_valid      <= 1'b0;
         s1_prod       <= '0;
         s1_psum       <= '0;
         PE_en_down    <= 1'b0;
         PE_data_down  <= '0;
         PE_en_right   <= 1'b0;
         PE_data_right <= '0;
         PE_w_pend     <= 1'b0;
         PE_err        <= 1'b0;
      end else begin
         s1_valid <= capture;
         if (capture) begin
            s1_prod <= prod_next;
            s1_psum <= PE_en_up ? $signed(PE_data_up) : '0;
         end

         if (do_swap)
            w_active <= w_shadow;

         if (load_fwd) begin
            w_shadow  <= PE_data_up[W_WIDTH-1:0];
            PE_w_pend <= 1'b1;
         end else if (do_swap) begin
            PE_w_pend <= 1'b0;
         end

         if (load_fwd) begin
            PE_en_down   <= 1'b1;
            PE_data_down <= PE_data_up;
            if (s1_valid)
               PE_err <= 1'b1;
         end else if (s1_valid) begin
            PE_en_down   <= 1'b1;
            PE_data_down <= mac_sum;
         end else begin
            PE_en_down   <= 1'b0;
         end

         PE_en_right <= PE_en_left;
         if (PE_en_left)
            PE_data_right <= PE_data_left;
      end
   end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Self-checking bench for pe_ws_dbuf: directed scenarios then random traffic against a scheduled-result model.
// Expected sums honour PE_SAT_EN when it is defined for the build.
module tb_pe_ws_dbuf;
   import pe_pkg::*;

   localparam int AW = 9;
   localparam int WW = 9;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mode = 1'b0;
   logic          swap = 1'b0;
   logic          en_up = 1'b0;
   logic [PW-1:0] data_up = '0;
   logic          en_left = 1'b0;
   logic [AW-1:0] data_left = '0;
   logic          en_down;
   logic [PW-1:0] data_down;
   logic          en_right;
   logic [AW-1:0] data_right;
   logic          w_pend;
   logic          err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   longint        m_active;
   longint        m_shadow;
   bit            m_pend;
   bit            m_err;
   bit            m_en_down;
   logic [PW-1:0] m_down;
   bit            m_en_right;
   logic [AW-1:0] m_right;
   logic [PW-1:0] due_val [int];

   always #5 clk = ~clk;

   pe_ws_dbuf #(
      .A_WIDTH (AW),
      .W_WIDTH (WW),
      .P_WIDTH (PW)
   ) dut (
      .PE_clk        (clk),
      .PE_rst        (rst),
      .PE_mode       (mode),
      .PE_swap       (swap),
      .PE_en_up      (en_up),
      .PE_data_up    (data_up),
      .PE_en_left    (en_left),
      .PE_data_left  (data_left),
      .PE_en_down    (en_down),
      .PE_data_down  (data_down),
      .PE_en_right   (en_right),
      .PE_data_right (data_right),
      .PE_w_pend     (w_pend),
      .PE_err        (err)
   );

   function automatic longint sx(input logic [31:0] v, input int w);
      longint r;
      r = longint'(v) & ((longint'(1) << w) - 1);
      if (v[w-1])
         r = r - (longint'(1) << w);
      return r;
   endfunction

   function automatic logic [PW-1:0] mac_model(input longint a, input longint w, input longint p);
      longint r;
      r = a * w + p;
`ifdef PE_SAT_EN
      if (r > 64'sh7FFFFFFF)
         r = 64'sh7FFFFFFF;
      else if (r < -64'sh80000000)
         r = -64'sh80000000;
`endif
      return r[PW-1:0];
   endfunction

   task automatic check_val(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Results are scheduled by the cycle they should appear in; a load claims its slot outright.
   task automatic model_edge();
      bit load;
      bit cap;
      if (rst) begin
         m_active = 0; m_shadow = 0; m_pend = 0; m_err = 0;
         m_en_down = 0; m_down = '0; m_en_right = 0; m_right = '0;
         due_val.delete();
      end else begin
         load = mode && en_up;
         cap  = !mode && (en_up || en_left);
         if (cap)
            due_val[cyc+1] = mac_model(en_left ? sx(32'(data_left), AW) : 0, m_active,
                                       en_up ? sx(data_up, PW) : 0);
         if (load) begin
            if (due_val.exists(cyc))
               m_err = 1;
            due_val[cyc] = data_up;
         end
         if (due_val.exists(cyc)) begin
            m_en_down = 1;
            m_down    = due_val[cyc];
            due_val.delete(cyc);
         end else begin
            m_en_down = 0;
         end
         if (swap && m_pend) begin
            m_active = m_shadow;
            m_pend   = 0;
         end
         if (load) begin
            m_shadow = sx(data_up, WW);
            m_pend   = 1;
         end
         m_en_right = en_left;
         if (en_left)
            m_right = data_left;
      end
      cyc++;
   endtask

   task automatic check_output();
      check_val("en_down", 32'(en_down), 32'(m_en_down));
      if (m_en_down)
         check_val("data_down", data_down, m_down);
      check_val("en_right", 32'(en_right), 32'(m_en_right));
      check_val("data_right", 32'(data_right), 32'(m_right));
      check_val("w_pend", 32'(w_pend), 32'(m_pend));
      check_val("err", 32'(err), 32'(m_err));
   endtask

   task automatic apply_stimulus(input bit r, input bit m, input bit s, input bit eu,
                                 input logic [PW-1:0] du, input bit el, input logic [AW-1:0] dl);
      rst = r; mode = m; swap = s; en_up = eu; data_up = du; en_left = el; data_left = dl;
      @(posedge clk);
      model_edge();
      #1;
      check_output();
   endtask

   task automatic idle();
      apply_stimulus(0, PE_MODE_COMP, 0, 0, '0, 0, '0);
   endtask

   initial begin
      apply_stimulus(1, 0, 0, 0, '0, 0, '0);
      apply_stimulus(1, 0, 0, 0, '0, 0, '0);
      check_val("rst_data_down", data_down, '0);

      // Zero active weight: only the psum comes through.
      apply_stimulus(0, PE_MODE_COMP, 0, 1, 32'd10, 1, 9'd5);
      idle();
      check_val("zero_weight_psum", data_down, 32'd10);
      idle();

      // Load -3, swap, then 7*-3+100.
      apply_stimulus(0, PE_MODE_LOAD, 0, 1, 32'h1FD, 0, '0);
      check_val("load_fwd", data_down, 32'h1FD);
      check_val("pend_set", 32'(w_pend), 32'd1);
      apply_stimulus(0, PE_MODE_COMP, 1, 0, '0, 0, '0);
      check_val("pend_clr", 32'(w_pend), 32'd0);
      apply_stimulus(0, PE_MODE_COMP, 0, 1, 32'd100, 1, 9'd7);
      idle();
      check_val("mac_79", data_down, 32'd79);
      idle();
      idle();

      // Double buffer: shadow=4 while active stays -3 until the swap edge.
      apply_stimulus(0, PE_MODE_LOAD, 0, 1, 32'd4, 0, '0);
      idle();
      for (int i = 0; i < 3; i++)
         apply_stimulus(0, PE_MODE_COMP, 0, 0, '0, 1, 9'd2);
      apply_stimulus(0, PE_MODE_COMP, 1, 0, '0, 1, 9'd2);
      apply_stimulus(0, PE_MODE_COMP, 0, 0, '0, 1, 9'd2);
      check_val("swap_cycle_old_w", data_down, -32'sd6);
      idle();
      check_val("after_swap_new_w", data_down, 32'd8);
      idle();
      idle();

      // Swap and load in one cycle.
      apply_stimulus(0, PE_MODE_LOAD, 0, 1, 32'd6, 0, '0);
      apply_stimulus(0, PE_MODE_LOAD, 1, 1, 32'd9, 0, '0);
      check_val("swap_load_pend", 32'(w_pend), 32'd1);
      apply_stimulus(0, PE_MODE_COMP, 0, 0, '0, 1, 9'd1);
      idle();
      check_val("swap_load_active", data_down, 32'd6);
      apply_stimulus(0, PE_MODE_COMP, 1, 0, '0, 0, '0);
      apply_stimulus(0, PE_MODE_COMP, 0, 0, '0, 1, 9'd1);
      idle();
      check_val("second_swap_active", data_down, 32'd9);
      idle();
      idle();

      // Overflow at the top of the signed range.
      apply_stimulus(0, PE_MODE_LOAD, 0, 1, 32'd1, 0, '0);
      apply_stimulus(0, PE_MODE_COMP, 1, 0, '0, 0, '0);
      apply_stimulus(0, PE_MODE_COMP, 0, 1, 32'h7FFFFFFF, 1, 9'd1);
      idle();
`ifdef PE_SAT_EN
      check_val("overflow", data_down, 32'h7FFFFFFF);
`else
      check_val("overflow", data_down, 32'h80000000);
`endif
      idle();

      // Collision: a load lands on the slot of a pending compute result.
      apply_stimulus(0, PE_MODE_COMP, 0, 0, '0, 1, 9'd3);
      apply_stimulus(0, PE_MODE_LOAD, 0, 1, 32'h55, 0, '0);
      check_val("collision_fwd", data_down, 32'h55);
      check_val("collision_err", 32'(err), 32'd1);
      idle();
      check_val("collision_dropped", 32'(en_down), 32'd0);
      check_val("err_sticky", 32'(err), 32'd1);

      // Reset in the middle of a stream.
      apply_stimulus(0, PE_MODE_COMP, 0, 1, 32'd11, 1, 9'd4);
      apply_stimulus(0, PE_MODE_COMP, 0, 1, 32'd12, 1, 9'd4);
      apply_stimulus(1, PE_MODE_COMP, 0, 0, '0, 0, '0);
      check_val("midrst_en_down", 32'(en_down), 32'd0);
      check_val("midrst_data_down", data_down, '0);
      check_val("midrst_data_right", 32'(data_right), 32'd0);
      check_val("midrst_err", 32'(err), 32'd0);
      apply_stimulus(0, PE_MODE_COMP, 0, 1, 32'd42, 1, 9'd5);
      idle();
      check_val("post_rst_psum", data_down, 32'd42);

      // Random traffic, including occasional loads, swaps, collisions and resets.
      for (int i = 0; i < 400; i++)
         apply_stimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
                        ($urandom_range(0, 7) == 0), 1'($urandom), $urandom,
                        1'($urandom), 9'($urandom));
      idle();
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
